// File: rtl/cvxif_copro_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cvxif_copro_router                                           |
// | Description : Routes one CV-X-IF core port to NrCopro coprocessors: issue  |
// |               decode, per-ID ownership table, commit routing, RR results.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cvxif_copro_router #(
    parameter int NrCopro    = 2,
    parameter int IdWidth    = 3,
    parameter int XLEN       = 64,
    parameter int InstrWidth = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       x_issue_valid_i,
    output logic                       x_issue_ready_o,
    input  logic [InstrWidth-1:0]      x_issue_instr_i,
    input  logic [IdWidth-1:0]         x_issue_id_i,
    input  logic [2*XLEN-1:0]          x_issue_rs_i,
    output logic                       x_issue_accept_o,
    output logic                       x_issue_writeback_o,
    input  logic                       x_commit_valid_i,
    input  logic [IdWidth-1:0]         x_commit_id_i,
    input  logic                       x_commit_kill_i,
    output logic                       x_result_valid_o,
    input  logic                       x_result_ready_i,
    output logic [IdWidth-1:0]         x_result_id_o,
    output logic [XLEN-1:0]            x_result_data_o,
    output logic                       x_result_we_o,
    input  logic [NrCopro-1:0]         cp_claim_i,
    output logic [InstrWidth-1:0]      cp_issue_instr_o,
    output logic [IdWidth-1:0]         cp_issue_id_o,
    output logic [2*XLEN-1:0]          cp_issue_rs_o,
    output logic [NrCopro-1:0]         cp_issue_valid_o,
    input  logic [NrCopro-1:0]         cp_issue_ready_i,
    input  logic [NrCopro-1:0]         cp_issue_accept_i,
    input  logic [NrCopro-1:0]         cp_issue_writeback_i,
    output logic [NrCopro-1:0]         cp_commit_valid_o,
    output logic [IdWidth-1:0]         cp_commit_id_o,
    output logic                       cp_commit_kill_o,
    input  logic [NrCopro-1:0]         cp_result_valid_i,
    output logic [NrCopro-1:0]         cp_result_ready_o,
    input  logic [NrCopro*IdWidth-1:0] cp_result_id_i,
    input  logic [NrCopro*XLEN-1:0]    cp_result_data_i,
    input  logic [NrCopro-1:0]         cp_result_we_i
);

    localparam int c_owner_w = (NrCopro > 1) ? $clog2(NrCopro) : 1;
    localparam int c_depth   = 2 ** IdWidth;

    logic [c_depth-1:0]   r_tbl_valid;
    logic [c_owner_w-1:0] r_tbl_owner [c_depth];
    logic [c_owner_w-1:0] r_rr_ptr;
    logic                 r_res_valid;
    logic [IdWidth-1:0]   r_res_id;
    logic [XLEN-1:0]      r_res_data;
    logic                 r_res_we;

    logic [c_owner_w-1:0] w_sel;
    logic                 w_claim_any;
    logic                 w_issue_go;
    logic                 w_issue_set;
    logic                 w_commit_hit;
    logic                 w_kill_clr;
    logic [c_owner_w-1:0] w_gnt;
    logic                 w_gnt_any;
    logic                 w_can_load;
    logic [IdWidth-1:0]   w_res_id;
    logic                 w_res_legal;
    logic                 w_res_clr;

    assign cp_issue_instr_o = x_issue_instr_i;
    assign cp_issue_id_o    = x_issue_id_i;
    assign cp_issue_rs_o    = x_issue_rs_i;
    assign cp_commit_id_o   = x_commit_id_i;
    assign cp_commit_kill_o = x_commit_kill_i;

    // Lowest-index claimer wins the instruction.
    always_comb begin
        w_sel       = '0;
        w_claim_any = 1'b0;
        for (int k = NrCopro - 1; k >= 0; k--) begin
            if (cp_claim_i[k]) begin
                w_sel       = c_owner_w'(k);
                w_claim_any = 1'b1;
            end
        end
    end

    // Busy check uses the registered valid bit, so a freed ID is issuable next cycle.
    assign w_issue_go          = x_issue_valid_i && !r_tbl_valid[x_issue_id_i];
    assign x_issue_ready_o     = w_issue_go && (!w_claim_any || cp_issue_ready_i[w_sel]);
    assign x_issue_accept_o    = w_issue_go && w_claim_any && cp_issue_accept_i[w_sel];
    assign x_issue_writeback_o = w_issue_go && w_claim_any && cp_issue_writeback_i[w_sel];
    assign w_issue_set         = w_issue_go && w_claim_any && cp_issue_ready_i[w_sel]
                                 && cp_issue_accept_i[w_sel];

    assign w_commit_hit = x_commit_valid_i && r_tbl_valid[x_commit_id_i];
    assign w_kill_clr   = w_commit_hit && x_commit_kill_i;

    always_comb begin
        cp_issue_valid_o  = '0;
        cp_commit_valid_o = '0;
        for (int k = 0; k < NrCopro; k++) begin
            cp_issue_valid_o[k]  = w_issue_go && w_claim_any && (w_sel == c_owner_w'(k));
            cp_commit_valid_o[k] = w_commit_hit && (r_tbl_owner[x_commit_id_i] == c_owner_w'(k));
        end
    end

    // Round-robin: scan from r_rr_ptr upward; reverse loop keeps the nearest hit.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        for (int i = NrCopro - 1; i >= 0; i--) begin
            idx = (int'(r_rr_ptr) + i) % NrCopro;
            if (cp_result_valid_i[idx]) begin
                w_gnt     = c_owner_w'(idx);
                w_gnt_any = 1'b1;
            end
        end
    end

    assign w_can_load  = !r_res_valid || x_result_ready_i;
    assign w_res_id    = cp_result_id_i[int'(w_gnt)*IdWidth +: IdWidth];
    // Stale results (killed, flushed or foreign owner) are consumed but dropped.
    assign w_res_legal = w_gnt_any && r_tbl_valid[w_res_id] && (r_tbl_owner[w_res_id] == w_gnt);
    assign w_res_clr   = w_can_load && w_res_legal;

    always_comb begin
        cp_result_ready_o = '0;
        for (int k = 0; k < NrCopro; k++) begin
            cp_result_ready_o[k] = w_can_load && w_gnt_any && (w_gnt == c_owner_w'(k));
        end
    end

    // Later assignments take priority: issue set beats kill/result clear beats flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tbl_valid <= '0;
            for (int e = 0; e < c_depth; e++) begin
                r_tbl_owner[e] <= '0;
            end
        end else begin
            if (flush_i) begin
                r_tbl_valid <= '0;
            end
            if (w_kill_clr) begin
                r_tbl_valid[x_commit_id_i] <= 1'b0;
            end
            if (w_res_clr) begin
                r_tbl_valid[w_res_id] <= 1'b0;
            end
            if (w_issue_set) begin
                r_tbl_valid[x_issue_id_i] <= 1'b1;
                r_tbl_owner[x_issue_id_i] <= w_sel;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr    <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_res_we    <= 1'b0;
        end else if (w_can_load) begin
            r_res_valid <= w_res_legal;
            if (w_res_legal) begin
                r_res_id   <= w_res_id;
                r_res_data <= cp_result_data_i[int'(w_gnt)*XLEN +: XLEN];
                r_res_we   <= cp_result_we_i[w_gnt];
            end
            if (w_gnt_any) begin
                if (int'(w_gnt) == NrCopro - 1) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_gnt + c_owner_w'(1);
                end
            end
        end
    end

    assign x_result_valid_o = r_res_valid;
    assign x_result_id_o    = r_res_id;
    assign x_result_data_o  = r_res_data;
    assign x_result_we_o    = r_res_we;

endmodule
`default_nettype wire

// File: doc/cvxif_copro_router.md
Name: cvxif_copro_router

Overview:
- Parametrised CV-X-IF router that connects the core's single coprocessor interface to NrCopro coprocessors. It generalises the current single example coprocessor hookup.
- Decodes ownership per instruction and tracks the owning coprocessor per instruction ID in a table.
- Routes commit/kill to the owner.
- Merges coprocessor results into one registered result port using round-robin arbitration.
- Sits between the cva6 core instance and the coprocessor array at top level.

Parameters:
- NrCopro, 2, number of attached coprocessors (1..8).
- IdWidth, 3, instruction ID width; the ID table has 2**IdWidth entries.
- XLEN, 64, operand/result data width.
- InstrWidth, 32, instruction word width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  core flush: invalidate all ID table entries.
- x_issue_valid_i  in  1  core issue request.
- x_issue_ready_o  out  1  issue handshake complete this cycle.
- x_issue_instr_i  in  InstrWidth  offloaded instruction.
- x_issue_id_i  in  IdWidth  instruction ID.
- x_issue_rs_i  in  2*XLEN  rs2,rs1 operands.
- x_issue_accept_o  out  1  instruction accepted by some coprocessor.
- x_issue_writeback_o  out  1  accepted instruction will write the register file.
- x_commit_valid_i  in  1  commit/kill event.
- x_commit_id_i  in  IdWidth  ID being committed.
- x_commit_kill_i  in  1  1 = kill, 0 = commit.
- x_result_valid_o  out  1  result available (registered).
- x_result_ready_i  in  1  core accepts the result.
- x_result_id_o  out  IdWidth  result ID.
- x_result_data_o  out  XLEN  result data.
- x_result_we_o  out  1  register write enable.
- cp_claim_i  in  NrCopro  per-coprocessor combinational decode hit on cp_issue_instr_o.
- cp_issue_instr_o  out  InstrWidth  broadcast instruction (= x_issue_instr_i).
- cp_issue_id_o  out  IdWidth  broadcast ID.
- cp_issue_rs_o  out  2*XLEN  broadcast operands.
- cp_issue_valid_o  out  NrCopro  one-hot issue valid to the selected coprocessor.
- cp_issue_ready_i  in  NrCopro  per-coprocessor issue ready.
- cp_issue_accept_i  in  NrCopro  per-coprocessor accept.
- cp_issue_writeback_i  in  NrCopro  per-coprocessor writeback.
- cp_commit_valid_o  out  NrCopro  one-hot commit to the owner.
- cp_commit_id_o  out  IdWidth  broadcast commit ID.
- cp_commit_kill_o  out  1  broadcast kill.
- cp_result_valid_i  in  NrCopro  per-coprocessor result valid.
- cp_result_ready_o  out  NrCopro  per-coprocessor result ready.
- cp_result_id_i  in  NrCopro*IdWidth  result IDs, copro k at [k*IdWidth +: IdWidth].
- cp_result_data_i  in  NrCopro*XLEN  result data.
- cp_result_we_i  in  NrCopro  result write enables.

Behaviour:
- Reset: ID table all invalid; RR pointer = 0; x_result_valid_o/id/data/we = 0.
- Combinational outputs at reset follow their inputs; cp_issue_valid_o is 0 when x_issue_valid_i = 0.
- ID table: per entry, valid bit plus owner index ($clog2(NrCopro), min 1 bit).
- Issue selection: sel = lowest index k with cp_claim_i[k]=1.
- Issue with busy ID (table[x_issue_id_i].valid = 1, registered value):
  - cp_issue_valid_o = 0, x_issue_ready_o = 0 (stall).
- Issue with ID free and no claimer:
  - x_issue_ready_o = 1, accept = 0, writeback = 0 (reject → illegal instruction in core).
  - No table write.
- Issue with ID free and a claimer:
  - cp_issue_valid_o[sel] = 1.
  - x_issue_ready_o = cp_issue_ready_i[sel].
  - accept/writeback are taken from sel.
  - On handshake with accept = 1: table[id] ← {valid, sel} at the clock edge.
  - Zero-latency combinational path.
- Commit:
  - If table[x_commit_id_i].valid: cp_commit_valid_o[owner] = 1 for one cycle.
  - If kill: the entry is cleared at the same edge.
  - Commit to an invalid entry is dropped silently.
- Result arbitration:
  - Round-robin among cp_result_valid_i, starting at the RR pointer.
  - The output stage loads when empty or when x_result_ready_i = 1.
  - cp_result_ready_o[g] = 1 only for grant g, and only when the stage can load.
  - After a grant to g, the pointer becomes (g+1) mod NrCopro.
- Result legality:
  - A result whose ID is not valid in the table, or whose owner ≠ k, is still consumed (ready = 1 when granted).
  - Such a result is discarded: the stage is not loaded and the table is not changed.
  - This covers stale results after a kill or flush.
- Legal result consumption: the stage loads id/data/we, and table[id] is cleared at the same edge.
- Output stage holds stable while x_result_valid_o & !x_result_ready_i. Full-throughput: one result per cycle.
- Simultaneous events on the same ID in one cycle:
  - Set (issue) wins over clear (kill/result).
  - Issue readiness uses the registered valid bit, so a freed ID becomes issuable the next cycle.
- flush_i:
  - Clears all table entries at the edge; lower priority than a same-cycle issue set.
  - Does not affect the output stage or the RR pointer.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Test Plan:
- Single issue: claim=2'b10, id=3, accept=1, writeback=1 → cp_issue_valid_o=2'b10, x_issue_accept_o=1; copro1 result id=3 data=0xABCD → x_result_valid_o next cycle with data 0xABCD, entry 3 cleared.
- Priority and reject:
  - claim=2'b11 → only copro0 gets valid.
  - claim=2'b00 → x_issue_ready_o=1, accept=0, no table write.
- Busy ID stall: issue id=5 accepted by copro0, second issue id=5 → ready=0 until copro0 returns result id=5, then ready=1 one cycle after the result is consumed.
- Kill: issue id=2 to copro1, commit kill id=2 → cp_commit_valid_o=2'b10, cp_commit_kill_o=1; later copro1 result id=2 is consumed with x_result_valid_o staying 0.
- Round-robin with backpressure: both copros hold valid results (ids 1 and 4), x_result_ready_i=0 for 3 cycles → outputs stable at id=1; then ready=1 → id=4 follows next cycle; pointer back at copro0.
- Flush and reset: 4 IDs outstanding, flush_i=1 → all IDs issuable next cycle; rst_ni asserted mid-result → x_result_valid_o=0 asynchronously.
